// File: rtl/rename_regfile_pkg.sv
// Shared constants and helpers for the rename register file.
// Holds the ROB tag width and the default geometry used by every rename_regfile file.
package rename_regfile_pkg;

    localparam int ROB_INDEX_BIT = 5;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 4;
    localparam int NIS_DEF  = 2;
    localparam int NCM_DEF  = 2;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rename_regfile_if.sv
// Read, issue and commit bundle between the pipeline and the rename register file.
// The master side drives indices, renames and commits; the slave side returns read data and occupancy.
interface rename_regfile_if
    import rename_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int ROB_W = ROB_INDEX_BIT,
    parameter int NRD   = NRD_DEF,
    parameter int NIS   = NIS_DEF,
    parameter int NCM   = NCM_DEF
);
    localparam int RW = idx_width(NREG);

    logic                  rdy_in;
    logic                  clear;

    logic [NRD*RW-1:0]     rd_id;
    logic [NRD*XLEN-1:0]   rd_val;
    logic [NRD*ROB_W-1:0]  rd_dep;
    logic [NRD-1:0]        rd_has_dep;

    logic [NIS-1:0]        is_valid;
    logic [NIS*RW-1:0]     is_rd;
    logic [NIS*ROB_W-1:0]  is_tag;

    logic [NCM-1:0]        cm_valid;
    logic [NCM*RW-1:0]     cm_rd;
    logic [NCM*XLEN-1:0]   cm_val;
    logic [NCM*ROB_W-1:0]  cm_tag;

    logic [RW:0]           busy_cnt;

    modport master (
        output rdy_in, clear, rd_id,
        output is_valid, is_rd, is_tag,
        output cm_valid, cm_rd, cm_val, cm_tag,
        input  rd_val, rd_dep, rd_has_dep, busy_cnt
    );

    modport slave (
        input  rdy_in, clear, rd_id,
        input  is_valid, is_rd, is_tag,
        input  cm_valid, cm_rd, cm_val, cm_tag,
        output rd_val, rd_dep, rd_has_dep, busy_cnt
    );

endinterface

// File: rtl/rename_regfile_rf_read_port.sv
// One combinational read port: table lookup with bypass from same-cycle commits.
// A bypass applies only when the commit is from the producer the entry is still waiting on.
module rf_read_port
    import rename_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int ROB_W = ROB_INDEX_BIT,
    parameter int NCM   = NCM_DEF,
    parameter int RW    = idx_width(NREG)
) (
    input  logic [RW-1:0]                rd_id,
    input  logic [NREG-1:0][XLEN-1:0]    rf_val,
    input  logic [NREG-1:0][ROB_W-1:0]   rf_dep,
    input  logic [NREG-1:0]              rf_has_dep,
    input  logic [NCM-1:0]               cm_valid,
    input  logic [NCM-1:0][RW-1:0]       cm_rd,
    input  logic [NCM-1:0][XLEN-1:0]     cm_val,
    input  logic [NCM-1:0][ROB_W-1:0]    cm_tag,
    output logic [XLEN-1:0]              rd_val,
    output logic [ROB_W-1:0]             rd_dep,
    output logic                         rd_has_dep
);

    always_comb begin
        rd_val     = rf_val[rd_id];
        rd_dep     = rf_dep[rd_id];
        rd_has_dep = rf_has_dep[rd_id];
        // Later commit ports are younger, so they take precedence on a tie.
        for (int k = 0; k < NCM; k++) begin
            if (cm_valid[k] && (cm_rd[k] == rd_id) && (rd_id != '0) &&
                rf_has_dep[rd_id] && (rf_dep[rd_id] == cm_tag[k])) begin
                rd_val     = cm_val[k];
                rd_dep     = '0;
                rd_has_dep = 1'b0;
            end
        end
        if (rd_id == '0) begin
            rd_val     = '0;
            rd_dep     = '0;
            rd_has_dep = 1'b0;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags and committed-value storage.
// Commits write values, issues rename destinations, clear drops every pending dependency.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int ROB_W = ROB_INDEX_BIT,
    parameter int NRD   = NRD_DEF,
    parameter int NIS   = NIS_DEF,
    parameter int NCM   = NCM_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    rename_regfile_if.slave   bus
);

    localparam int RW = idx_width(NREG);

    logic [NRD-1:0][RW-1:0]     rd_id_a;
    logic [NRD-1:0][XLEN-1:0]   rd_val_a;
    logic [NRD-1:0][ROB_W-1:0]  rd_dep_a;
    logic [NRD-1:0]             rd_has_dep_a;

    logic [NIS-1:0][RW-1:0]     is_rd_a;
    logic [NIS-1:0][ROB_W-1:0]  is_tag_a;
    logic [NCM-1:0][RW-1:0]     cm_rd_a;
    logic [NCM-1:0][XLEN-1:0]   cm_val_a;
    logic [NCM-1:0][ROB_W-1:0]  cm_tag_a;

    logic [NREG-1:0][XLEN-1:0]  rf_q,  rf_d;
    logic [NREG-1:0][ROB_W-1:0] dep_q, dep_d;
    logic [NREG-1:0]            hd_q,  hd_d;
    logic [RW:0]                busy_q, busy_d;

    assign rd_id_a  = bus.rd_id;
    assign is_rd_a  = bus.is_rd;
    assign is_tag_a = bus.is_tag;
    assign cm_rd_a  = bus.cm_rd;
    assign cm_val_a = bus.cm_val;
    assign cm_tag_a = bus.cm_tag;

    assign bus.rd_val     = rd_val_a;
    assign bus.rd_dep     = rd_dep_a;
    assign bus.rd_has_dep = rd_has_dep_a;
    assign bus.busy_cnt   = busy_q;

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            rf_read_port #(
                .XLEN  (XLEN),
                .NREG  (NREG),
                .ROB_W (ROB_W),
                .NCM   (NCM),
                .RW    (RW)
            ) u_port (
                .rd_id      (rd_id_a[p]),
                .rf_val     (rf_q),
                .rf_dep     (dep_q),
                .rf_has_dep (hd_q),
                .cm_valid   (bus.cm_valid),
                .cm_rd      (cm_rd_a),
                .cm_val     (cm_val_a),
                .cm_tag     (cm_tag_a),
                .rd_val     (rd_val_a[p]),
                .rd_dep     (rd_dep_a[p]),
                .rd_has_dep (rd_has_dep_a[p])
            );
        end
    endgenerate

    always_comb begin
        rf_d   = rf_q;
        dep_d  = dep_q;
        hd_d   = hd_q;
        busy_d = '0;

        // Commit clearing is applied first so that a same-cycle rename of the
        // same register, processed afterwards, wins over it.
        for (int k = 0; k < NCM; k++) begin
            if (bus.cm_valid[k] && (cm_rd_a[k] != '0)) begin
                rf_d[cm_rd_a[k]] = cm_val_a[k];
                if (dep_q[cm_rd_a[k]] == cm_tag_a[k]) begin
                    dep_d[cm_rd_a[k]] = '0;
                    hd_d[cm_rd_a[k]]  = 1'b0;
                end
            end
        end

        if (bus.clear) begin
            dep_d = '0;
            hd_d  = '0;
        end else begin
            for (int j = 0; j < NIS; j++) begin
                if (bus.is_valid[j] && (is_rd_a[j] != '0)) begin
                    dep_d[is_rd_a[j]] = is_tag_a[j];
                    hd_d[is_rd_a[j]]  = 1'b1;
                end
            end
        end

        for (int i = 1; i < NREG; i++) begin
            busy_d = busy_d + {{RW{1'b0}}, hd_d[i]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rf_q   <= '0;
            dep_q  <= '0;
            hd_q   <= '0;
            busy_q <= '0;
        end else if (bus.rdy_in) begin
            rf_q   <= rf_d;
            dep_q  <= dep_d;
            hd_q   <= hd_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios plus randomized traffic against a behavioural model.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int ROB_W = ROB_INDEX_BIT;
    localparam int NRD   = 4;
    localparam int NIS   = 2;
    localparam int NCM   = 2;
    localparam int RW    = 5;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    rename_regfile_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
                        .NRD(NRD), .NIS(NIS), .NCM(NCM)) bus ();

    rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
                     .NRD(NRD), .NIS(NIS), .NCM(NCM)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0]  m_val [NREG];
    logic [ROB_W-1:0] m_dep [NREG];
    bit               m_hd  [NREG];

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0; m_dep[i] = '0; m_hd[i] = 1'b0;
        end
    endtask

    function automatic bit issue_targets(input int r);
        for (int j = 0; j < NIS; j++)
            if (bus.is_valid[j] && int'(bus.is_rd[j*RW +: RW]) == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic [XLEN-1:0]  nv [NREG];
        logic [ROB_W-1:0] nd [NREG];
        bit               nh [NREG];
        int r;
        if (!bus.rdy_in) return;
        nv = m_val; nd = m_dep; nh = m_hd;
        for (int k = 0; k < NCM; k++) begin
            r = int'(bus.cm_rd[k*RW +: RW]);
            if (bus.cm_valid[k] && r != 0) begin
                nv[r] = bus.cm_val[k*XLEN +: XLEN];
                if (!bus.clear && m_dep[r] == bus.cm_tag[k*ROB_W +: ROB_W] && !issue_targets(r)) begin
                    nd[r] = '0; nh[r] = 1'b0;
                end
            end
        end
        if (bus.clear) begin
            for (int i = 0; i < NREG; i++) begin nd[i] = '0; nh[i] = 1'b0; end
        end else begin
            for (int j = 0; j < NIS; j++) begin
                r = int'(bus.is_rd[j*RW +: RW]);
                if (bus.is_valid[j] && r != 0) begin
                    nd[r] = bus.is_tag[j*ROB_W +: ROB_W]; nh[r] = 1'b1;
                end
            end
        end
        m_val = nv; m_dep = nd; m_hd = nh;
    endtask

    function automatic int model_busy();
        int c = 0;
        for (int i = 1; i < NREG; i++) c += int'(m_hd[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        if (rst_in) model_edge();
        #1;
    endtask

    task automatic idle();
        bus.rdy_in = 1'b1; bus.clear = 1'b0;
        bus.is_valid = '0; bus.is_rd = '0; bus.is_tag = '0;
        bus.cm_valid = '0; bus.cm_rd = '0; bus.cm_val = '0; bus.cm_tag = '0;
    endtask

    task automatic set_issue(input int j, input int rd, input int tag);
        bus.is_valid[j] = 1'b1;
        bus.is_rd[j*RW +: RW] = RW'(rd);
        bus.is_tag[j*ROB_W +: ROB_W] = ROB_W'(tag);
    endtask

    task automatic set_commit(input int k, input int rd, input logic [XLEN-1:0] val, input int tag);
        bus.cm_valid[k] = 1'b1;
        bus.cm_rd[k*RW +: RW] = RW'(rd);
        bus.cm_val[k*XLEN +: XLEN] = val;
        bus.cm_tag[k*ROB_W +: ROB_W] = ROB_W'(tag);
    endtask

    task automatic read0(input int id);
        bus.rd_id[0 +: RW] = RW'(id);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.rd_id = '0;
        model_reset();
        #12;
        read0(5);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h0 || bus.rd_has_dep[0] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_x5: val=%h hd=%b busy=%0d, want 0/0/0", bus.rd_val[31:0], bus.rd_has_dep[0], bus.busy_cnt);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        n_tests++;
        if (bus.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %0d want 0", bus.busy_cnt);
        end
    endtask

    task automatic test_bypass();
        idle(); set_issue(0, 3, 7);
        tick(); idle(); read0(3);
        n_tests++;
        if (bus.rd_has_dep[0] !== 1'b1 || bus.rd_dep[4:0] !== 5'd7 || bus.busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_x3: hd=%b dep=%0d busy=%0d, want 1/7/1", bus.rd_has_dep[0], bus.rd_dep[4:0], bus.busy_cnt);
        end
        set_commit(0, 3, 32'hDEADBEEF, 7); #1;
        n_tests++;
        if (bus.rd_val[31:0] !== 32'hDEADBEEF || bus.rd_has_dep[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_x3: val=%h hd=%b, want deadbeef/0", bus.rd_val[31:0], bus.rd_has_dep[0]);
        end
        tick(); idle(); read0(3);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'hDEADBEEF || bus.rd_has_dep[0] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL commit_x3: val=%h hd=%b busy=%0d, want deadbeef/0/0", bus.rd_val[31:0], bus.rd_has_dep[0], bus.busy_cnt);
        end
    endtask

    task automatic test_issue_over_commit();
        idle(); set_issue(0, 4, 2);
        tick(); idle(); set_issue(0, 4, 9); set_commit(0, 4, 32'h11, 2);
        tick(); idle(); read0(4);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h11 || bus.rd_has_dep[0] !== 1'b1 || bus.rd_dep[4:0] !== 5'd9) begin
            n_fail++;
            $display("FAIL issue_over_commit_x4: val=%h hd=%b dep=%0d, want 11/1/9", bus.rd_val[31:0], bus.rd_has_dep[0], bus.rd_dep[4:0]);
        end
    endtask

    task automatic test_port_priority();
        idle(); set_issue(0, 6, 1); set_issue(1, 6, 3);
        set_commit(0, 8, 32'hA, 0); set_commit(1, 8, 32'hB, 0);
        tick(); idle(); read0(6);
        n_tests++;
        if (bus.rd_dep[4:0] !== 5'd3 || bus.rd_has_dep[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_prio_x6: dep=%0d hd=%b, want 3/1", bus.rd_dep[4:0], bus.rd_has_dep[0]);
        end
        read0(8);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'hB || bus.busy_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL commit_prio_x8: val=%h busy=%0d, want b/2", bus.rd_val[31:0], bus.busy_cnt);
        end
    endtask

    task automatic test_clear();
        for (int r = 1; r <= 10; r += 2) begin
            idle(); set_issue(0, r, r); set_issue(1, r + 1, r + 1);
            tick();
        end
        idle();
        n_tests++;
        if (bus.busy_cnt !== 6'd10) begin
            n_fail++;
            $display("FAIL rename_1_10_busy: got %0d want 10", bus.busy_cnt);
        end
        bus.clear = 1'b1; set_commit(0, 2, 32'h55, 17);
        tick(); idle();
        n_tests++;
        if (bus.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL clear_busy: got %0d want 0", bus.busy_cnt);
        end
        for (int r = 1; r <= 10; r++) begin
            read0(r);
            n_tests++;
            if (bus.rd_has_dep[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_hd_x%0d: got %b want 0", r, bus.rd_has_dep[0]);
            end
        end
        read0(2);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h55) begin
            n_fail++;
            $display("FAIL clear_commit_x2: got %h want 55", bus.rd_val[31:0]);
        end
    endtask

    task automatic test_x0_and_stall();
        idle(); set_issue(0, 0, 4); set_commit(0, 0, 32'hFF, 0);
        tick(); idle(); read0(0);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h0 || bus.rd_has_dep[0] !== 1'b0 || bus.rd_dep[4:0] !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_ignored: val=%h hd=%b dep=%0d, want 0/0/0", bus.rd_val[31:0], bus.rd_has_dep[0], bus.rd_dep[4:0]);
        end
        set_issue(0, 9, 2);
        tick(); idle();
        bus.rdy_in = 1'b0; set_issue(0, 7, 12); set_commit(1, 9, 32'h99, 2);
        read0(9);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h99 || bus.rd_has_dep[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bypass_x9: val=%h hd=%b, want 99/0", bus.rd_val[31:0], bus.rd_has_dep[0]);
        end
        tick(); tick(); idle(); read0(7);
        n_tests++;
        if (bus.rd_val[31:0] !== 32'h0 || bus.rd_has_dep[0] !== 1'b0 || bus.busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL stall_x7: val=%h hd=%b busy=%0d, want 0/0/1", bus.rd_val[31:0], bus.rd_has_dep[0], bus.busy_cnt);
        end
        read0(9);
        n_tests++;
        if (bus.rd_has_dep[0] !== 1'b1 || bus.rd_val[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_x9_held: hd=%b val=%h, want 1/0", bus.rd_has_dep[0], bus.rd_val[31:0]);
        end
    endtask

    task automatic test_random();
        int r, id, bad;
        logic [XLEN-1:0]  ev;
        logic [ROB_W-1:0] ed;
        bit               eh;
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.rdy_in = ($urandom_range(0, 7) != 0);
            bus.clear  = ($urandom_range(0, 24) == 0);
            for (int j = 0; j < NIS; j++)
                if ($urandom_range(0, 1) == 1) set_issue(j, $urandom_range(0, 11), $urandom_range(0, 31));
            for (int k = 0; k < NCM; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 11);
                    set_commit(k, r, $urandom, ($urandom_range(0, 3) != 0) ? int'(m_dep[r]) : $urandom_range(0, 31));
                end
            end
            for (int p = 0; p < NRD; p++) bus.rd_id[p*RW +: RW] = RW'($urandom_range(0, 11));
            #1;
            for (int p = 0; p < NRD; p++) begin
                id = int'(bus.rd_id[p*RW +: RW]);
                ev = m_val[id]; ed = m_dep[id]; eh = m_hd[id];
                for (int k = 0; k < NCM; k++)
                    if (id != 0 && bus.cm_valid[k] && int'(bus.cm_rd[k*RW +: RW]) == id &&
                        m_hd[id] && m_dep[id] == bus.cm_tag[k*ROB_W +: ROB_W]) begin
                        ev = bus.cm_val[k*XLEN +: XLEN]; eh = 1'b0;
                    end
                bad = (bus.rd_val[p*XLEN +: XLEN] !== ev || bus.rd_has_dep[p] !== eh ||
                       (eh && bus.rd_dep[p*ROB_W +: ROB_W] !== ed)) ? 1 : 0;
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL rand_read c%0d p%0d x%0d: val=%h hd=%b dep=%0d, want %h/%b/%0d",
                             c, p, id, bus.rd_val[p*XLEN +: XLEN], bus.rd_has_dep[p],
                             bus.rd_dep[p*ROB_W +: ROB_W], ev, eh, ed);
                end
            end
            tick();
            n_tests++;
            if (int'(bus.busy_cnt) != model_busy()) begin
                n_fail++;
                $display("FAIL rand_busy c%0d: got %0d want %0d", c, bus.busy_cnt, model_busy());
            end
        end
    endtask

    task automatic test_async_reset();
        idle(); set_issue(0, 3, 5); set_commit(0, 2, 32'h1234, 0);
        tick();
        idle(); set_issue(0, 5, 6); set_commit(1, 3, 32'hCAFE, 5);
        bus.rd_id = '0;
        bus.rd_id[0 +: RW] = RW'(2);
        bus.rd_id[RW +: RW] = RW'(3);
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.busy_cnt !== 6'd0 || bus.rd_val[31:0] !== 32'h0 || bus.rd_val[63:32] !== 32'h0 ||
            bus.rd_has_dep[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: busy=%0d v2=%h v3=%h hd=%b, want all 0",
                     bus.busy_cnt, bus.rd_val[31:0], bus.rd_val[63:32], bus.rd_has_dep[1:0]);
        end
        tick();
        rst_in = 1'b1;
        idle(); set_issue(1, 3, 1);
        tick(); idle(); read0(3);
        n_tests++;
        if (bus.busy_cnt !== 6'd1 || bus.rd_has_dep[0] !== 1'b1 || bus.rd_dep[4:0] !== 5'd1 || bus.rd_val[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_issue: busy=%0d hd=%b dep=%0d val=%h, want 1/1/1/0",
                     bus.busy_cnt, bus.rd_has_dep[0], bus.rd_dep[4:0], bus.rd_val[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_issue_over_commit();
        test_port_priority();
        test_clear();
        test_x0_and_stall();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
